// File: rtl/eth_vlg_pkg.sv
// Shared types for the Ethernet TX path: arbiter source ids, FSM states, header layout.
// No logic; imported by the TX arbiter and its selector.
package eth_vlg_pkg;

  typedef enum logic {
    ARP  = 1'b0,
    IPV4 = 1'b1
  } tx_arb_src_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    STREAM = 2'd2
  } tx_arb_fsm_t;

  // 14-byte on-wire Ethernet header width
  localparam int ETH_HDR_W = 112;

  // Frame descriptor carried from a source to the MAC
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [15:0] etyp;
    logic [15:0] len;
  } tx_hdr_t;

  function automatic logic [1:0] src_onehot(input tx_arb_src_t s);
    return (s == ARP) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/eth_vlg_tx_arb_sel.sv
// Combinational two-way selector: a lone request wins, a tie goes to the source not granted last.
// Zero latency; no backpressure (pure function of its inputs).
// Backpressure: none.
module eth_vlg_tx_arb_sel
  import eth_vlg_pkg::*;
(
  input  logic arp_req,
  input  logic ipv4_req,
  input  logic last_ipv4,
  output logic sel_vld,
  output logic sel_ipv4
);

  always_comb begin
    sel_vld  = arp_req | ipv4_req;
    sel_ipv4 = ipv4_req;
    if (arp_req && ipv4_req) begin
      sel_ipv4 = ~last_ipv4;
    end
  end

endmodule

// File: rtl/eth_vlg_tx_arb.sv
// Frame arbiter ARP/IPv4 -> MAC; ETH_TX_ARB_ARP_PRIO_EN gives ARP strict priority on ties.
// Latency: header on out_* 1 cycle after rdy sampled; payload bytes delayed 1 cycle.
// Backpressure: frame held in OFFER until out_acc; a source idle for GAP_TMO cycles is aborted.
module eth_vlg_tx_arb
  import eth_vlg_pkg::*;
#(
  parameter int GAP_TMO    = 16,
  parameter bit VERBOSE    = 1'b0,
  parameter     DUT_STRING = ""
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        arp_rdy,
  input  logic [15:0] arp_len,
  input  logic [47:0] arp_dst_mac,
  input  logic [15:0] arp_etyp,
  output logic        arp_acc,
  input  logic [7:0]  arp_dat,
  input  logic        arp_val,
  output logic        arp_done,

  input  logic        ipv4_rdy,
  input  logic [15:0] ipv4_len,
  input  logic [47:0] ipv4_dst_mac,
  input  logic [15:0] ipv4_etyp,
  output logic        ipv4_acc,
  input  logic [7:0]  ipv4_dat,
  input  logic        ipv4_val,
  output logic        ipv4_done,

  output logic        out_rdy,
  output logic [15:0] out_len,
  output logic [47:0] out_dst_mac,
  output logic [15:0] out_etyp,
  input  logic        out_acc,
  output logic [7:0]  out_dat,
  output logic        out_val,
  output logic        out_done,
  output logic        out_err,
  output logic [1:0]  gnt
);

  localparam logic [7:0] GAP_LIM = 8'(GAP_TMO);

  tx_arb_fsm_t state_q, state_d;
  tx_hdr_t     hdr_q, hdr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  acc_q, acc_d;
  logic [1:0]  done_q, done_d;
  logic        out_rdy_q, out_rdy_d;
  logic [7:0]  out_dat_q, out_dat_d;
  logic        out_val_q, out_val_d;
  logic        out_done_q, out_done_d;
  logic        out_err_q, out_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  idle_q, idle_d;

  tx_hdr_t     arp_hdr, ipv4_hdr, sel_hdr;
  tx_arb_src_t sel_src;
  logic        sel_vld, sel_ipv4, last_ipv4, take;
  logic        src_val;
  logic [7:0]  src_dat;

  assign arp_hdr  = {arp_dst_mac, arp_etyp, arp_len};
  assign ipv4_hdr = {ipv4_dst_mac, ipv4_etyp, ipv4_len};

  eth_vlg_tx_arb_sel u_sel (
    .arp_req   (arp_rdy),
    .ipv4_req  (ipv4_rdy),
    .last_ipv4 (last_ipv4),
    .sel_vld   (sel_vld),
    .sel_ipv4  (sel_ipv4)
  );

  assign sel_src = tx_arb_src_t'(sel_ipv4);
  assign sel_hdr = (sel_src == ARP) ? arp_hdr : ipv4_hdr;
  // While a done pulse is out, the finishing source has not yet dropped rdy; do not re-grant it.
  assign take    = (state_q == IDLE) && sel_vld && !(|done_q);

  assign src_val = (gnt_q[0] & arp_val) | (gnt_q[1] & ipv4_val);
  assign src_dat = gnt_q[1] ? ipv4_dat : arp_dat;

`ifdef ETH_TX_ARB_ARP_PRIO_EN
  assign last_ipv4 = 1'b1;
`else
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = sel_ipv4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end

  assign last_ipv4 = ptr_q;
`endif

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    gnt_d      = gnt_q;
    out_rdy_d  = out_rdy_q;
    out_dat_d  = out_dat_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    acc_d      = 2'b00;
    done_d     = 2'b00;
    out_val_d  = 1'b0;
    out_done_d = 1'b0;
    out_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (take) begin
          if (sel_hdr.len == 16'd0) begin
            acc_d  = src_onehot(sel_src);
            done_d = src_onehot(sel_src);
          end else begin
            hdr_d     = sel_hdr;
            gnt_d     = src_onehot(sel_src);
            out_rdy_d = 1'b1;
            state_d   = OFFER;
          end
        end
      end

      OFFER: begin
        if (out_acc) begin
          out_rdy_d = 1'b0;
          acc_d     = gnt_q;
          cnt_d     = 16'd0;
          idle_d    = 8'd0;
          state_d   = STREAM;
        end
      end

      STREAM: begin
        out_dat_d = src_dat;
        if (src_val) begin
          out_val_d = 1'b1;
          idle_d    = 8'd0;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == hdr_q.len - 16'd1) begin
            out_done_d = 1'b1;
            done_d     = gnt_q;
            gnt_d      = 2'b00;
            state_d    = IDLE;
          end
        end else begin
          idle_d = idle_q + 8'd1;
          if (idle_d == GAP_LIM) begin
            out_err_d = 1'b1;
            done_d    = gnt_q;
            gnt_d     = 2'b00;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      gnt_q      <= 2'b00;
      acc_q      <= 2'b00;
      done_q     <= 2'b00;
      out_rdy_q  <= 1'b0;
      out_dat_q  <= 8'd0;
      out_val_q  <= 1'b0;
      out_done_q <= 1'b0;
      out_err_q  <= 1'b0;
      cnt_q      <= 16'd0;
      idle_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      gnt_q      <= gnt_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      out_rdy_q  <= out_rdy_d;
      out_dat_q  <= out_dat_d;
      out_val_q  <= out_val_d;
      out_done_q <= out_done_d;
      out_err_q  <= out_err_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign arp_acc     = acc_q[0];
  assign ipv4_acc    = acc_q[1];
  assign arp_done    = done_q[0];
  assign ipv4_done   = done_q[1];
  assign out_rdy     = out_rdy_q;
  assign out_len     = hdr_q.len;
  assign out_dst_mac = hdr_q.dst_mac;
  assign out_etyp    = hdr_q.etyp;
  assign out_dat     = out_dat_q;
  assign out_val     = out_val_q;
  assign out_done    = out_done_q;
  assign out_err     = out_err_q;
  assign gnt         = gnt_q;

endmodule

// File: tb/tb_eth_vlg_tx_arb.sv
// Self-checking bench for eth_vlg_tx_arb: vector table, arbitration/reset sequences, random frames.
module tb_eth_vlg_tx_arb;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_rdy, arp_acc, arp_val, arp_done;
  logic [15:0] arp_len, arp_etyp;
  logic [47:0] arp_dst_mac;
  logic [7:0]  arp_dat;
  logic        ipv4_rdy, ipv4_acc, ipv4_val, ipv4_done;
  logic [15:0] ipv4_len, ipv4_etyp;
  logic [47:0] ipv4_dst_mac;
  logic [7:0]  ipv4_dat;
  logic        out_rdy, out_acc, out_val, out_done, out_err;
  logic [15:0] out_len, out_etyp;
  logic [47:0] out_dst_mac;
  logic [7:0]  out_dat;
  logic [1:0]  gnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  eth_vlg_tx_arb #(.GAP_TMO(GAP), .VERBOSE(1'b0), .DUT_STRING("tb")) dut (
    .clk(clk), .rst(rst),
    .arp_rdy(arp_rdy), .arp_len(arp_len), .arp_dst_mac(arp_dst_mac), .arp_etyp(arp_etyp),
    .arp_acc(arp_acc), .arp_dat(arp_dat), .arp_val(arp_val), .arp_done(arp_done),
    .ipv4_rdy(ipv4_rdy), .ipv4_len(ipv4_len), .ipv4_dst_mac(ipv4_dst_mac), .ipv4_etyp(ipv4_etyp),
    .ipv4_acc(ipv4_acc), .ipv4_dat(ipv4_dat), .ipv4_val(ipv4_val), .ipv4_done(ipv4_done),
    .out_rdy(out_rdy), .out_len(out_len), .out_dst_mac(out_dst_mac), .out_etyp(out_etyp),
    .out_acc(out_acc), .out_dat(out_dat), .out_val(out_val), .out_done(out_done),
    .out_err(out_err), .gnt(gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int s;
    int len;
    int nbytes;
    int acc_dly;
    int exp_fwd;
    int exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drv_rdy(input int s, input logic r, input logic [15:0] l,
                         input logic [47:0] m, input logic [15:0] e);
    if (s == 0) begin
      arp_rdy = r; arp_len = l; arp_dst_mac = m; arp_etyp = e;
    end else begin
      ipv4_rdy = r; ipv4_len = l; ipv4_dst_mac = m; ipv4_etyp = e;
    end
  endtask

  task automatic drv_dat(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin arp_val = v; arp_dat = d; end
    else        begin ipv4_val = v; ipv4_dat = d; end
  endtask

  function automatic logic acc_of(input int s);
    return (s == 0) ? arp_acc : ipv4_acc;
  endfunction

  function automatic logic done_of(input int s);
    return (s == 0) ? arp_done : ipv4_done;
  endfunction

  function automatic logic [1:0] oh(input int s);
    return (s == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [17:0] ctl_bits();
    return {out_rdy, out_val, out_done, out_err, gnt, arp_acc, arp_done, ipv4_acc, ipv4_done, out_dat};
  endfunction

  // One frame from source s; gaps of up to gap_max idle cycles between bytes.
  task automatic run_frame(input string tag, input int s, input int len, input int nbytes,
                           input int acc_dly, input int gap_max, input int exp_fwd, input int exp_err);
    logic [7:0]  data[$];
    int          drv_cyc[$];
    logic [47:0] mac;
    logic [15:0] etyp;
    int rdy_cnt, acc_cnt, acc_cyc, done_cnt, done_cyc, odone_cnt, oerr_cnt, err_cyc;
    int fwd, bad, lat_bad, sync_bad, hdr_bad, last_ov, sent, wait_gap, post, budget;
    bit go;
    rdy_cnt = 0; acc_cnt = 0; acc_cyc = -1; done_cnt = 0; done_cyc = -2; odone_cnt = 0;
    oerr_cnt = 0; err_cyc = -1; fwd = 0; bad = 0; lat_bad = 0; sync_bad = 0; hdr_bad = 0;
    last_ov = -1; sent = 0; wait_gap = 0; post = 0; go = 1'b0;
    mac  = {16'($urandom), 32'($urandom)};
    etyp = 16'($urandom);
    for (int i = 0; i < nbytes; i++) data.push_back(8'($urandom));
    budget = 100 + GAP + 5 * (nbytes + len) + acc_dly;
    @(negedge clk);
    drv_rdy(s, 1'b1, 16'(len), mac, etyp);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (out_rdy) begin
        rdy_cnt++;
        if (out_len !== 16'(len) || out_dst_mac !== mac || out_etyp !== etyp || gnt !== oh(s)) hdr_bad++;
      end
      if (acc_of(s)) begin acc_cnt++; acc_cyc = cyc; end
      if (out_val) begin
        if (fwd >= nbytes || out_dat !== data[fwd]) bad++;
        if (fwd >= drv_cyc.size() || cyc != drv_cyc[fwd] + 1) lat_bad++;
        fwd++;
        last_ov = cyc;
      end
      if (done_of(s)) begin done_cnt++; done_cyc = cyc; end
      if (out_done && !(done_of(s) && out_val)) sync_bad++;
      if (out_err && !(done_of(s) && !out_val)) sync_bad++;
      if (out_done) odone_cnt++;
      if (out_err) begin oerr_cnt++; err_cyc = cyc; end
      out_acc = out_rdy && (rdy_cnt == acc_dly + 1);
      if (acc_of(s)) begin
        drv_rdy(s, 1'b0, 16'(len), mac, etyp);
        go = 1'b1;
        drv_dat(s, 1'b0, 8'd0);
      end else if (go && sent < nbytes && wait_gap == 0) begin
        drv_dat(s, 1'b1, data[sent]);
        drv_cyc.push_back(cyc);
        sent++;
        wait_gap = $urandom_range(gap_max, 0);
      end else begin
        if (wait_gap > 0) wait_gap--;
        drv_dat(s, 1'b0, 8'($urandom));
      end
      drv_dat(1 - s, 1'($urandom), 8'($urandom));
      if (done_cnt > 0) post++;
      if (done_cnt > 0 && sent >= nbytes && post >= 3) break;
    end
    drv_rdy(s, 1'b0, 16'd0, 48'd0, 16'd0);
    drv_dat(0, 1'b0, 8'd0);
    drv_dat(1, 1'b0, 8'd0);
    out_acc = 1'b0;
    chk({tag, " src acc pulses"}, acc_cnt, 1);
    chk({tag, " src done pulses"}, done_cnt, 1);
    chk({tag, " out_rdy cycles"}, rdy_cnt, (len == 0) ? 0 : acc_dly + 1);
    chk({tag, " header/gnt while offered"}, hdr_bad, 0);
    chk({tag, " bytes forwarded"}, fwd, exp_fwd);
    chk({tag, " data errors"}, bad, 0);
    chk({tag, " 1-cycle latency errors"}, lat_bad, 0);
    chk({tag, " out_done pulses"}, odone_cnt, (len != 0 && exp_err == 0) ? 1 : 0);
    chk({tag, " out_err pulses"}, oerr_cnt, exp_err);
    chk({tag, " done/err alignment"}, sync_bad, 0);
    chk({tag, " gnt after frame"}, gnt, 2'b00);
    if (len == 0) chk({tag, " zero-len acc/done same cycle"}, done_cyc, acc_cyc);
    if (exp_err != 0) chk({tag, " abort cycle"}, err_cyc, ((last_ov >= 0) ? last_ov : acc_cyc) + GAP);
  endtask

  // ARP sends two 4-byte frames back to back, IPv4 one; both request together.
  task automatic run_rr(input int e0, input int e1, input int e2);
    int g[3];
    int pend[2];
    int sent[2];
    bit go[2];
    int ng, nout, ndone;
    g = '{-1, -1, -1}; pend = '{2, 1}; sent = '{0, 0}; go = '{1'b0, 1'b0};
    ng = 0; nout = 0; ndone = 0;
    @(negedge clk);
    drv_rdy(0, 1'b1, 16'd4, 48'h111111111111, 16'h0806);
    drv_rdy(1, 1'b1, 16'd4, 48'h222222222222, 16'h0800);
    for (int k = 0; k < 300 && ndone < 3; k++) begin
      @(negedge clk);
      if (out_val) nout++;
      out_acc = out_rdy;
      for (int s = 0; s < 2; s++) begin
        if (acc_of(s)) begin
          if (ng < 3) g[ng] = s;
          ng++;
          drv_rdy(s, 1'b0, 16'd4, 48'd0, 16'd0);
          go[s] = 1'b1;
          sent[s] = 0;
          drv_dat(s, 1'b0, 8'd0);
        end else if (go[s] && sent[s] < 4) begin
          drv_dat(s, 1'b1, 8'(sent[s]));
          sent[s]++;
        end else begin
          drv_dat(s, 1'b0, 8'd0);
        end
        if (done_of(s)) begin
          ndone++;
          go[s] = 1'b0;
          pend[s]--;
          if (pend[s] > 0) drv_rdy(s, 1'b1, 16'd4, (s == 0) ? 48'h111111111111 : 48'h222222222222,
                                   (s == 0) ? 16'h0806 : 16'h0800);
        end
      end
    end
    out_acc = 1'b0;
    drv_rdy(0, 1'b0, 16'd0, 48'd0, 16'd0);
    drv_rdy(1, 1'b0, 16'd0, 48'd0, 16'd0);
    drv_dat(0, 1'b0, 8'd0);
    drv_dat(1, 1'b0, 8'd0);
    chk("arb grant count", ng, 3);
    chk("arb grant 1st", g[0], e0);
    chk("arb grant 2nd", g[1], e1);
    chk("arb grant 3rd", g[2], e2);
    chk("arb bytes", nout, 12);
  endtask

  initial begin
    vec_t tbl[7];
    int   seen, pulses, s, len, nbytes, fwd_ref, err_ref;
    bit   go;

    tbl[0] = '{0, 28, 28, 2, 28, 0};   // basic ARP frame, MAC accepts late
    tbl[1] = '{1, 10, 5, 0, 5, 1};     // IPv4 stalls after 5 bytes
    tbl[2] = '{0, 0, 0, 0, 0, 0};      // zero-length request
    tbl[3] = '{0, 8, 12, 1, 8, 0};     // source over-runs its length
    tbl[4] = '{1, 1, 1, 3, 1, 0};      // single-byte frame
    tbl[5] = '{1, 6, 0, 1, 0, 1};      // source never sends
    tbl[6] = '{0, 3, 3, 0, 3, 0};

    rst = 1'b1;
    out_acc = 1'b0;
    drv_rdy(0, 1'b0, 16'd0, 48'd0, 16'd0);
    drv_rdy(1, 1'b0, 16'd0, 48'd0, 16'd0);
    drv_dat(0, 1'b0, 8'd0);
    drv_dat(1, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    chk("in reset ctl", ctl_bits(), 18'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after reset ctl", ctl_bits(), 18'd0);
    chk("after reset hdr", |{out_len, out_dst_mac, out_etyp}, 1'b0);

`ifdef ETH_TX_ARB_ARP_PRIO_EN
    run_rr(0, 0, 1);
`else
    run_rr(0, 1, 0);
`endif

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].s, tbl[i].len, tbl[i].nbytes,
                tbl[i].acc_dly, 0, tbl[i].exp_fwd, tbl[i].exp_err);
    end

    // Asynchronous reset in the middle of a 20-byte ARP frame
    seen = 0;
    go = 1'b0;
    @(negedge clk);
    drv_rdy(0, 1'b1, 16'd20, 48'h0a0b0c0d0e0f, 16'h0806);
    for (int k = 0; k < 100 && seen < 3; k++) begin
      @(negedge clk);
      if (out_val) seen++;
      out_acc = out_rdy;
      if (arp_acc) begin
        drv_rdy(0, 1'b0, 16'd20, 48'h0a0b0c0d0e0f, 16'h0806);
        go = 1'b1;
      end
      drv_dat(0, go, 8'(k));
    end
    chk("reached byte 3 before reset", seen, 3);
    rst = 1'b1;
    drv_dat(0, 1'b0, 8'd0);
    out_acc = 1'b0;
    #1;
    chk("async reset ctl", ctl_bits(), 18'd0);
    chk("async reset hdr", |{out_len, out_dst_mac, out_etyp}, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_done || out_err || arp_done || ipv4_done || out_val || out_rdy) pulses++;
    end
    chk("no pulses after reset", pulses, 0);
    run_frame("post-reset", 0, 5, 5, 1, 0, 5, 0);

    // Random frames against the length/stall rules
    for (int i = 0; i < 25; i++) begin
      s   = $urandom_range(1, 0);
      len = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(40, 1);
      if (len == 0)                       nbytes = 0;
      else if ($urandom_range(1, 0) == 1) nbytes = $urandom_range(len - 1, 0);
      else                                nbytes = len + $urandom_range(3, 0);
      fwd_ref = (nbytes < len) ? nbytes : len;
      err_ref = (nbytes < len) ? 1 : 0;
      run_frame($sformatf("rnd%0d", i), s, len, nbytes, $urandom_range(3, 0), 3, fwd_ref, err_ref);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
